// File: rtl/controle_lancer_if.sv
// Button-side bus of the dice-roller sequencer: raw active-low buttons in,
// conditioned control/status levels out, plus the FSM state for observation.
interface controle_lancer_if;
  // No valid/ready handshake here: buttons are free-running levels sampled
  // every cycle; suivant is a one-cycle strobe, the other outputs are levels.
  logic       suivant_n;
  logic       lancer_n;
  logic       suivant;
  logic       lancer;
  logic       res_valide;
  logic       occupe;
  logic [1:0] etat;

  modport master (
    output suivant_n, lancer_n,
    input  suivant, lancer, res_valide, occupe, etat
  );

  modport slave (
    input  suivant_n, lancer_n,
    output suivant, lancer, res_valide, occupe, etat
  );
endinterface

// File: rtl/controle_lancer.sv
// Dice-roller sequencer: synchronises and debounces both buttons, then runs
// the IDLE/ROLLING/SHOW roll state machine with a minimum tumble time.
module controle_lancer #(
  parameter int DEB_CYCLES  = 500000,
  parameter int DEB_W       = 20,
  parameter int ROLL_CYCLES = 25000000,
  parameter int ROLL_W      = 25
) (
  input  logic             clk,
  input  logic             reset_n,
  controle_lancer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROLLING = 2'd1,
    SHOW    = 2'd2
  } state_t;

  localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [ROLL_W-1:0] ROLL_MAX = ROLL_W'(ROLL_CYCLES - 1);

  // Bit 0 carries the suivant button, bit 1 the lancer button.
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       deb;
  logic [1:0]       deb_prev;
  logic [DEB_W-1:0] deb_cnt [2];
  logic [1:0]       press;

  state_t            state;
  logic [ROLL_W-1:0] roll_cnt;
  logic              suivant_q;
  logic              lancer_q;
  logic              res_q;
  logic              occupe_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= '1;
      sync2    <= '1;
      deb      <= '1;
      deb_prev <= '1;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      sync1    <= {bus.lancer_n, bus.suivant_n};
      sync2    <= sync1;
      deb_prev <= deb;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_MAX) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Only the debounced falling edge (press) is an event; releases are ignored.
  assign press = deb_prev & ~deb;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      roll_cnt  <= '0;
      suivant_q <= 1'b0;
      lancer_q  <= 1'b0;
      res_q     <= 1'b0;
      occupe_q  <= 1'b0;
    end else begin
      suivant_q <= 1'b0;
      case (state)
        IDLE, SHOW: begin
          // Roll wins over a simultaneous suivant press.
          if (press[1]) begin
            state    <= ROLLING;
            roll_cnt <= '0;
            lancer_q <= 1'b1;
            occupe_q <= 1'b1;
            res_q    <= 1'b0;
          end else if (press[0]) begin
            state     <= IDLE;
            suivant_q <= 1'b1;
            res_q     <= 1'b0;
          end
        end
        ROLLING: begin
          if (roll_cnt == ROLL_MAX && deb[1]) begin
            state    <= SHOW;
            lancer_q <= 1'b0;
            occupe_q <= 1'b0;
            res_q    <= 1'b1;
          end else if (roll_cnt != ROLL_MAX) begin
            roll_cnt <= roll_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          lancer_q <= 1'b0;
          occupe_q <= 1'b0;
          res_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.suivant    = suivant_q;
  assign bus.lancer     = lancer_q;
  assign bus.res_valide = res_q;
  assign bus.occupe     = occupe_q;
  assign bus.etat       = state;

endmodule

// File: tb/tb_controle_lancer.sv
// Directed bench for controle_lancer with DEB_CYCLES=4, ROLL_CYCLES=8; each
// step queues the expected output vector per cycle and checks it after the edge.
module tb_controle_lancer;

  logic clk;
  logic reset_n;

  controle_lancer_if bus ();

  controle_lancer #(
    .DEB_CYCLES (4),
    .DEB_W      (3),
    .ROLL_CYCLES(8),
    .ROLL_W     (4)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector layout: {suivant, lancer, res_valide, occupe}
  localparam logic [3:0] VZ = 4'b0000;
  localparam logic [3:0] VS = 4'b1000;
  localparam logic [3:0] VR = 4'b0101;
  localparam logic [3:0] VV = 4'b0010;

  logic [3:0] exp_q [$];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  string      phase    = "init";

  function automatic logic [3:0] observed();
    return {bus.suivant, bus.lancer, bus.res_valide, bus.occupe};
  endfunction

  task automatic check_vec(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = observed();
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input int n, input logic [3:0] v);
    logic [3:0] exp;
    for (int i = 0; i < n; i++) exp_q.push_back(v);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL %s cyc=%0d observed=empty_queue expected=vector", phase, cyc);
      end else begin
        exp = exp_q.pop_front();
        check_vec(phase, exp);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d observed=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n       = 1'b1;
    bus.suivant_n = 1'b1;
    bus.lancer_n  = 1'b1;

    // Asynchronous reset with buttons released
    @(posedge clk);
    #5 reset_n = 1'b0;
    #1 check_vec("reset_async", VZ);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 check_vec("reset_held", VZ);
    reset_n = 1'b0;
    reset_n = 1'b1;
    phase = "after_reset";
    step(20, VZ);

    // Clean suivant press in IDLE, then release gives nothing
    phase = "clean_suivant";
    bus.suivant_n = 1'b0;
    step(6, VZ);
    step(1, VS);
    step(3, VZ);
    phase = "suivant_release";
    bus.suivant_n = 1'b1;
    step(12, VZ);

    // Bouncy press: low/high/low then held
    phase = "bouncy";
    bus.suivant_n = 1'b0;
    step(1, VZ);
    bus.suivant_n = 1'b1;
    step(1, VZ);
    bus.suivant_n = 1'b0;
    step(6, VZ);
    step(1, VS);
    step(3, VZ);
    bus.suivant_n = 1'b1;
    step(10, VZ);

    // Short roll: exactly ROLL_CYCLES of lancer, res_valide on the falling edge
    phase = "short_roll";
    bus.lancer_n = 1'b0;
    step(6, VZ);
    bus.lancer_n = 1'b1;
    step(8, VR);
    step(5, VV);

    // SHOW + suivant press: pulse and res_valide drops on the same edge
    phase = "show_suivant";
    bus.suivant_n = 1'b0;
    step(6, VV);
    step(1, VS);
    step(3, VZ);
    bus.suivant_n = 1'b1;
    step(10, VZ);

    // Held roll with suivant presses dropped during ROLLING
    phase = "held_roll";
    bus.lancer_n = 1'b0;
    step(6, VZ);
    step(8, VR);
    bus.suivant_n = 1'b0;
    step(8, VR);
    bus.suivant_n = 1'b1;
    step(8, VR);
    bus.lancer_n = 1'b1;
    step(6, VR);
    step(5, VV);

    // Simultaneous presses from SHOW: roll wins, no suivant pulse
    phase = "simultaneous";
    bus.lancer_n  = 1'b0;
    bus.suivant_n = 1'b0;
    step(6, VV);
    bus.lancer_n  = 1'b1;
    bus.suivant_n = 1'b1;
    step(8, VR);
    step(4, VV);

    // Reset in the middle of a roll with the roll button still held
    phase = "pre_reset_roll";
    bus.lancer_n = 1'b0;
    step(6, VV);
    step(3, VR);
    #3 reset_n = 1'b0;
    #1 check_vec("reset_mid_roll", VZ);
    @(posedge clk);
    #1 check_vec("reset_mid_roll_held", VZ);
    reset_n = 1'b1;
    phase = "held_through_reset";
    step(6, VZ);
    bus.lancer_n = 1'b1;
    step(8, VR);
    step(3, VV);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/controle_lancer.md
# controle_lancer

Sequencing controller for the tabletop-RPG dice roller. Turns the two raw active-low push-buttons (next die type, roll) into clean control signals for the die-selection and roll datapaths. It synchronises and debounces both buttons and runs a roll state machine that enforces a minimum tumble time. It also locks out die-type changes while a roll is in progress and flags when the displayed result is valid. It sits between the board buttons and the `suivant` / `lancer` inputs of the selection and roll blocks in the top level.

## Interface
- `DEB_CYCLES`, default 500000: consecutive stable samples needed to accept a button level change (10 ms at 50 MHz); must be ≥ 2 and < 2^`DEB_W`.
- `DEB_W`, default 20: debounce counter width.
- `ROLL_CYCLES`, default 25000000: minimum number of cycles spent in ROLLING (0.5 s at 50 MHz); must be ≥ 1 and < 2^`ROLL_W`.
- `ROLL_W`, default 25: roll counter width.
- `clk` in 1: system clock; all logic is on the rising edge.
- `reset_n` in 1: asynchronous active-low reset.
- `suivant_n` in 1: raw "next die type" button, 0 when pressed, asynchronous.
- `lancer_n` in 1: raw "roll" button, 0 when pressed, asynchronous.
- `suivant` out 1: registered one-cycle pulse that advances the die-type selector.
- `lancer` out 1: registered level, high while ROLLING; the roll datapath tumbles while it is high and freezes when it is low.
- `res_valide` out 1: registered, high in SHOW; the result display is valid.
- `occupe` out 1: registered, high in ROLLING; mirrors `lancer` and is used for status LEDs.

## Operation
- **Reset:** both synchroniser stages = 1, debounced levels = 1 (released), edge-history registers = 1, both counters = 0, state = IDLE, all outputs = 0.
- **Input conditioning:** each button passes through a 2-flop synchroniser, then an independent debouncer.
- **Debouncer:**
  - While the synchronised sample differs from the debounced level, the counter increments each cycle.
  - When the counter is at `DEB_CYCLES`-1 and the sample still differs, the debounced level takes the sample and the counter clears.
  - Any sample equal to the debounced level clears the counter, so bounces restart the count.
- **Press event:** the debounced level goes 1→0 (compared against the previous-cycle register). A release is never an event.
- **IDLE:**
  - A `lancer` press moves to ROLLING.
  - A `suivant` press pulses `suivant` and stays in IDLE.
- **ROLLING:**
  - On entry the roll counter clears, then increments each cycle. It saturates at `ROLL_CYCLES`-1.
  - Exit to SHOW happens at the edge where the counter = `ROLL_CYCLES`-1 and the debounced roll level = 1 (released). Holding the button therefore extends the roll.
  - `suivant` presses are dropped: no pulse, not queued.
  - Further `lancer` presses have no effect.
- **SHOW:**
  - A `lancer` press goes back to ROLLING, with the roll counter cleared.
  - A `suivant` press pulses `suivant` and goes to IDLE, because the result no longer matches the die type.
- **Simultaneous presses** (both press events in the same cycle, in IDLE or SHOW): roll wins, go to ROLLING, and the `suivant` press is dropped.
- **Outputs are registered decodes of the next state:**
  - `lancer` = `occupe` = (next state == ROLLING).
  - `res_valide` = (next state == SHOW).
  - `suivant` = 1 only for a `suivant` press accepted in that cycle.
- **Reset mid-roll:** outputs drop to 0 asynchronously. After release the block restarts in IDLE with buttons treated as released. A button still held at reset release becomes a press event once debounced.

## Timing
- **Edge numbering:** raw input low before edge 0 and held.
  - Synchroniser output low after edge 1.
  - Debounced level falls at edge `DEB_CYCLES`+1.
  - The registered response (`suivant` pulse, or `lancer` rising) appears at edge `DEB_CYCLES`+2.
- `suivant` is high for exactly one cycle per accepted press.
- `lancer` stays high for max(`ROLL_CYCLES`, time until the roll button is released and debounced) cycles, never fewer than `ROLL_CYCLES`.
- `res_valide` rises at the same edge at which `lancer` falls. There is no cycle with both low between ROLLING and SHOW, and no cycle with both high.
- **Throughput:** at most one press event per button per 2·`DEB_CYCLES` cycles (press plus release).

## Test plan
All scenarios use `DEB_CYCLES`=4 and `ROLL_CYCLES`=8.
- **Reset:** assert `reset_n`=0 mid-cycle with buttons high → all outputs 0 immediately, without waiting for a clock edge. After release, outputs stay 0 for 20 cycles.
- **Clean suivant press in IDLE:** `suivant_n` low before edge 0 and held 10 cycles → `suivant` high only after edge 6 for one cycle. `lancer` and `res_valide` stay 0. Releasing gives no pulse.
- **Bouncy press:** `suivant_n` toggles low/high/low at 1-cycle spacing, then holds low → a single `suivant` pulse, 6 edges after the last low transition is first sampled.
- **Short roll:** `lancer_n` low for 6 cycles, then high → `lancer` high from edge 6 for exactly 8 cycles. `res_valide` rises on the same edge `lancer` falls.
- **Held roll:** `lancer_n` held low for 30 cycles → `lancer` stays high until 4+2 cycles after the release is sampled. `suivant` presses during the roll produce no pulse.
- **SHOW transitions:**
  - In SHOW, press `suivant` → pulse, and `res_valide` falls on the same edge.
  - Return to SHOW, then press both buttons on the same cycle → `lancer` rises and no `suivant` pulse occurs.
